// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared types and width helper for the N:1 round-robin mux
//
// Purpose : selection-mode and output-register state enums, and the
//           select/channel-id width helper used by interface, top and arbiter.
// Ports   : none (package)
package mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Channel-id width; never below 1 so a 2-input mux still has a real select bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_to_1_rr_if.sv
// rtl/mux_n_to_1_rr_if.sv - handshake/data bundle between producers, mux and consumer
//
// Purpose : groups the per-channel inputs, selection controls and the single
//           registered output stream of mux_n_to_1_rr.
// Signals : in_data/in_valid/in_ready  per-channel producer handshake
//           mode/sel                   selection controls
//           out_data/out_chan/out_valid/out_ready  consumer handshake
//           sel_err                    fixed-mode out-of-range select pulse
//           out_parity                 XOR of the output word (MUX_PARITY_EN only)
// Modports: slave  - the mux itself
//           master - the environment driving it
interface mux_n_to_1_rr_if #(
    parameter int NUM_INPUTS = 16,
    parameter int DATA_WIDTH = 8
);
    import mux_pkg::*;

    localparam int SEL_W = sel_width(NUM_INPUTS);

    logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data;
    logic [NUM_INPUTS-1:0]            in_valid;
    logic [NUM_INPUTS-1:0]            in_ready;
    logic                             mode;
    logic [SEL_W-1:0]                 sel;
    logic [DATA_WIDTH-1:0]            out_data;
    logic [SEL_W-1:0]                 out_chan;
    logic                             out_valid;
    logic                             out_ready;
    logic                             sel_err;
`ifdef MUX_PARITY_EN
    logic                             out_parity;
`endif

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid, sel_err
`ifdef MUX_PARITY_EN
        , output out_parity
`endif
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid, sel_err
`ifdef MUX_PARITY_EN
        , input out_parity
`endif
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose : grants the first requesting channel after the last-grant pointer,
//           wrapping modulo NUM_INPUTS.
// Ports   : req    in  NUM_INPUTS  request vector
//           last   in  SEL_W       index of previous grant
//           enable in  1           when low no grant is issued
//           grant  out NUM_INPUTS  one-hot grant (or zero)
//           idx    out SEL_W       encoded index of grant (0 when none)
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_INPUTS = 16
) (
    input  logic [NUM_INPUTS-1:0]                 req,
    input  logic [sel_width(NUM_INPUTS)-1:0]      last,
    input  logic                                  enable,
    output logic [NUM_INPUTS-1:0]                 grant,
    output logic [sel_width(NUM_INPUTS)-1:0]      idx
);
    localparam int SEL_W = sel_width(NUM_INPUTS);

    always_comb begin
        logic found;
        int   c;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        // Scan last+1 .. last+NUM_INPUTS; last itself is checked last, so a
        // lone requester on the previous grant still wins.
        for (int i = 1; i <= NUM_INPUTS; i++) begin
            c = int'(last) + i;
            if (c >= NUM_INPUTS) c = c - NUM_INPUTS;
            if (enable && !found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = SEL_W'(c);
            end
        end
    end

endmodule

// File: rtl/mux_n_to_1_rr.sv
// rtl/mux_n_to_1_rr.sv - registered N:1 mux with fixed-select or round-robin arbitration
//
// Purpose : picks one valid producer per cycle and registers its word into a
//           single output stage (latency 1, full throughput under out_ready).
// Ports   : clk  in  sole clock, rising edge
//           rst  in  asynchronous active-high reset
//           bus  slave modport of mux_n_to_1_rr_if (see interface header)
// Option  : MUX_PARITY_EN adds bus.out_parity, registered alongside out_data.
module mux_n_to_1_rr
    import mux_pkg::*;
#(
    parameter int NUM_INPUTS = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    mux_n_to_1_rr_if.slave  bus
);
    localparam int SEL_W = sel_width(NUM_INPUTS);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_mux;
    logic [SEL_W-1:0]        chan_q, last_q, arb_idx, load_idx;
    logic                    sel_err_q;
    logic [NUM_INPUTS-1:0]   arb_grant, fx_grant, grant, ready;
    logic                    rr_mode, sel_ok, can_load, load;

    assign rr_mode  = (mode_e'(bus.mode) == MODE_RR);
    assign can_load = (state_q == ST_EMPTY) || bus.out_ready;

    // Fixed-mode grant by per-channel compare; an out-of-range sel matches nothing.
    always_comb begin
        fx_grant = '0;
        sel_ok   = 1'b0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                sel_ok      = 1'b1;
                fx_grant[k] = bus.in_valid[k];
            end
        end
    end

    rr_arbiter #(.NUM_INPUTS(NUM_INPUTS)) u_arb (
        .req    (bus.in_valid),
        .last   (last_q),
        .enable (rr_mode && can_load),
        .grant  (arb_grant),
        .idx    (arb_idx)
    );

    assign grant    = rr_mode ? arb_grant : fx_grant;
    assign ready    = (can_load && !rst) ? grant : '0;
    assign load     = |ready;
    assign load_idx = rr_mode ? arb_idx : bus.sel;

    always_comb begin
        data_mux = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (ready[k]) data_mux = bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (load) state_d = ST_FULL;
            ST_FULL:  if (bus.out_ready && !load) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            data_q    <= '0;
            chan_q    <= '0;
            sel_err_q <= 1'b0;
            last_q    <= SEL_W'(NUM_INPUTS - 1);
        end else begin
            state_q   <= state_d;
            sel_err_q <= !rr_mode && !sel_ok;
            if (load) begin
                data_q <= data_mux;
                chan_q <= load_idx;
            end
            // Pointer moves only on round-robin grants so fixed mode leaves it intact.
            if (load && rr_mode) last_q <= arb_idx;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.sel_err   = sel_err_q;

`ifdef MUX_PARITY_EN
    logic parity_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       parity_q <= 1'b0;
        else if (load) parity_q <= ^data_mux;
    end
    assign bus.out_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_n_to_1_rr.sv
// tb/tb_mux_n_to_1_rr.sv - directed bench for mux_n_to_1_rr (16- and 12-input instances)
module tb_mux_n_to_1_rr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mux_n_to_1_rr_if #(.NUM_INPUTS(16), .DATA_WIDTH(8)) a16 ();
    mux_n_to_1_rr_if #(.NUM_INPUTS(12), .DATA_WIDTH(8)) a12 ();

    mux_n_to_1_rr #(.NUM_INPUTS(16), .DATA_WIDTH(8)) dut16 (.clk(clk), .rst(rst), .bus(a16));
    mux_n_to_1_rr #(.NUM_INPUTS(12), .DATA_WIDTH(8)) dut12 (.clk(clk), .rst(rst), .bus(a12));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Registered outputs are checked 2 time units after the edge; inputs change there too.
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) a16.in_data[k*8 +: 8] = 8'(k + 1);
        for (int k = 0; k < 12; k++) a12.in_data[k*8 +: 8] = 8'(k + 1);
        a16.in_valid = 16'hFFFF; a16.mode = 1'b0; a16.sel = 4'd0; a16.out_ready = 1'b1;
        a12.in_valid = 12'h000;  a12.mode = 1'b0; a12.sel = 4'd0; a12.out_ready = 1'b1;

        // Reset state; in_ready held low while rst is high even with valid inputs.
        #3;
        check("rst_in_ready", a16.in_ready, 0);
        tick;
        tick;
        check("rst_out_valid", a16.out_valid, 0);
        check("rst_out_data", a16.out_data, 0);
        check("rst_out_chan", a16.out_chan, 0);
        check("rst_sel_err", a16.sel_err, 0);
        rst = 1'b0;

        // Fixed mode, sel stepped 0..15; each word appears one cycle later.
        for (int s = 0; s < 16; s++) begin
            a16.sel = 4'(s);
            #1;
            check($sformatf("fx_ready_%0d", s), a16.in_ready, 64'(1) << s);
            tick;
            check($sformatf("fx_data_%0d", s), a16.out_data, 64'(s + 1));
            check($sformatf("fx_chan_%0d", s), a16.out_chan, 64'(s));
            check($sformatf("fx_valid_%0d", s), a16.out_valid, 1);
        end

        // Round-robin, all valid: pointer still at 15 so grants go 0..15 then 0.
        a16.mode = 1'b1;
        for (int i = 0; i < 17; i++) begin
            #1;
            check($sformatf("rr_ready_%0d", i), a16.in_ready, 64'(1) << (i % 16));
            tick;
            check($sformatf("rr_chan_%0d", i), a16.out_chan, 64'(i % 16));
            check($sformatf("rr_data_%0d", i), a16.out_data, 64'((i % 16) + 1));
            check($sformatf("rr_valid_%0d", i), a16.out_valid, 1);
        end

        // Only channels 3 and 12 requesting: alternate 3,12,3,12.
        a16.in_valid = 16'h1008;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr2_ready_%0d", i), a16.in_ready, (i % 2 == 0) ? 64'h0008 : 64'h1000);
            tick;
            check($sformatf("rr2_chan_%0d", i), a16.out_chan, (i % 2 == 0) ? 64'd3 : 64'd12);
        end

        // Backpressure: load 0x05 on channel 4, then hold it for 5 cycles.
        a16.mode = 1'b0; a16.sel = 4'd4; a16.in_valid = 16'hFFFF;
        tick;
        check("bp_load_data", a16.out_data, 8'h05);
        a16.out_ready = 1'b0;
        #1;
        check("bp_ready0", a16.in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick;
            check($sformatf("bp_data_%0d", i), a16.out_data, 8'h05);
            check($sformatf("bp_chan_%0d", i), a16.out_chan, 4);
            check($sformatf("bp_valid_%0d", i), a16.out_valid, 1);
            check($sformatf("bp_ready_%0d", i), a16.in_ready, 0);
        end
        a16.sel = 4'd7; a16.out_ready = 1'b1;
        #1;
        check("bp_rel_ready", a16.in_ready, 64'h0080);
        tick;
        check("bp_rel_data", a16.out_data, 8'h08);
        check("bp_rel_chan", a16.out_chan, 7);

        // 12-input instance: sel=13 is out of range.
        a12.in_valid = 12'hFFF; a12.sel = 4'd2;
        tick;
        check("s12_load_data", a12.out_data, 8'h03);
        check("s12_load_valid", a12.out_valid, 1);
        a12.sel = 4'd13;
        #1;
        check("s12_bad_ready", a12.in_ready, 0);
        tick;
        check("s12_drain_valid", a12.out_valid, 0);
        check("s12_err_0", a12.sel_err, 1);
        for (int i = 1; i < 4; i++) begin
            tick;
            check($sformatf("s12_err_%0d", i), a12.sel_err, 1);
            check($sformatf("s12_ready_%0d", i), a12.in_ready, 0);
        end
        a12.sel = 4'd1;
        tick;
        check("s12_ok_err", a12.sel_err, 0);
        check("s12_ok_data", a12.out_data, 8'h02);
        check("s12_ok_valid", a12.out_valid, 1);

        // Mid-stream async reset while FULL; pointer stored at 12 so next RR grant is 13.
        a16.mode = 1'b1;
        #1;
        check("mr_ready", a16.in_ready, 64'h2000);
        tick;
        check("mr_chan", a16.out_chan, 13);
        check("mr_full", a16.out_valid, 1);
        rst = 1'b1;
        #1;
        check("mr_async_valid", a16.out_valid, 0);
        check("mr_async_data", a16.out_data, 0);
        check("mr_async_ready", a16.in_ready, 0);
        check("mr_async_v12", a12.out_valid, 0);
        tick;
        rst = 1'b0;
        #1;
        check("mr_first_ready", a16.in_ready, 64'h0001);
        tick;
        check("mr_first_chan", a16.out_chan, 0);
        check("mr_first_data", a16.out_data, 8'h01);
        check("mr_first_valid", a16.out_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
